// File: rtl/tod_counter_pkg.sv
// Shared definitions for the time-of-day counter: digit widths, field limits,
// binary-to-BCD conversion and the 24h-to-12h hour mapping.
package tod_counter_pkg;

  localparam int SEC_U_W  = 4;
  localparam int SEC_T_W  = 3;
  localparam int MIN_U_W  = 4;
  localparam int MIN_T_W  = 3;
  localparam int HOUR_U_W = 4;
  localparam int HOUR_T_W = 2;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // 0..59 binary to {tens[2:0], units[3:0]}
  function automatic logic [6:0] bin2bcd_6(input logic [5:0] v);
    return {3'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // 0..23 binary to {tens[1:0], units[3:0]}
  function automatic logic [5:0] bin2bcd_5(input logic [4:0] v);
    return {2'(v / 5'd10), 4'(v % 5'd10)};
  endfunction

  // 24h hour (0..23) to 12h display hour (1..12)
  function automatic logic [4:0] to_12h(input logic [4:0] h);
    logic [4:0] r;
    if (h == 5'd0) begin
      r = 5'd12;
    end else if (h > 5'd12) begin
      r = h - 5'd12;
    end else begin
      r = h;
    end
    return r;
  endfunction

endpackage

// File: rtl/tod_counter_bcd_digit.sv
// One BCD digit counting 0..MAX. Priority: load, then clear, then count.
// carry_out flags the enabled step that wraps MAX back to 0.
module bcd_digit #(
  parameter int W   = 4,
  parameter int MAX = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] q,
  output logic [W-1:0] d,
  output logic         carry_out
);

  localparam logic [W-1:0] LAST = W'(MAX);

  logic [W-1:0] digit_q;
  logic [W-1:0] digit_d;

  // Next digit value: load beats clear beats count.
  always_comb begin
    digit_d = digit_q;
    if (ld) begin
      digit_d = ld_val;
    end else if (clr) begin
      digit_d = '0;
    end else if (en) begin
      digit_d = (digit_q == LAST) ? '0 : digit_q + W'(1);
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign q         = digit_q;
  assign d         = digit_d;
  assign carry_out = en && (digit_q == LAST);

endmodule

// File: rtl/tod_counter.sv
// Time-of-day counter: prescaler, BCD hh:mm:ss, 12h/24h display, range-checked
// load, second tick and day rollover strobes.
// Optional feature: define TOD_ALARM_EN to add the hh:mm alarm compare and ports.
module tod_counter
  import tod_counter_pkg::*;
#(
  parameter int DIV = 100_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                load,
  input  logic [4:0]          load_hours,
  input  logic [5:0]          load_minutes,
  input  logic [5:0]          load_seconds,
  input  logic                mode_12h,
  output logic [SEC_U_W-1:0]  sec_units,
  output logic [SEC_T_W-1:0]  sec_tens,
  output logic [MIN_U_W-1:0]  min_units,
  output logic [MIN_T_W-1:0]  min_tens,
  output logic [HOUR_U_W-1:0] hour_units,
  output logic [HOUR_T_W-1:0] hour_tens,
  output logic                pm,
  output logic                tick,
  output logic                rollover
`ifdef TOD_ALARM_EN
  ,
  input  logic                alarm_arm,
  input  logic [4:0]          alarm_hours,
  input  logic [5:0]          alarm_minutes,
  output logic                alarm_hit
`endif
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [5:0]       disp_q, disp_d;
  logic             pm_q, pm_d;
  logic             tick_q, tick_d;
  logic             rollover_q, rollover_d;
  logic             valid_q;

  logic       load_ok, adv, step, hour_en, day_wrap;
  logic [6:0] ld_sec, ld_min;
  logic [5:0] ld_hr;
  logic [4:0] hour_next;

  logic [SEC_U_W-1:0]  su_q, su_d;
  logic [SEC_T_W-1:0]  st_q, st_d;
  logic [MIN_U_W-1:0]  mu_q, mu_d;
  logic [MIN_T_W-1:0]  mt_q, mt_d;
  logic [HOUR_U_W-1:0] hu_q, hu_d;
  logic [HOUR_T_W-1:0] ht_q, ht_d;
  logic su_co, st_co, mu_co, mt_co, hu_co, ht_co;

  // A load only counts when every field is in range; otherwise it is invisible.
  assign load_ok = load
                && (load_hours   <= 5'(HOUR_MAX))
                && (load_minutes <= 6'(MIN_MAX))
                && (load_seconds <= 6'(SEC_MAX));
  assign adv  = enable && (cnt_q == CNT_LAST);
  assign step = adv && !load_ok;

  assign ld_sec = bin2bcd_6(load_seconds);
  assign ld_min = bin2bcd_6(load_minutes);
  assign ld_hr  = bin2bcd_5(load_hours);

  // Hours are held as 24h BCD; 23 -> 00 is decoded from both digits together.
  assign hour_en  = mt_co;
  assign day_wrap = hour_en && (ht_q == 2'd2) && (hu_q == 4'd3);

  bcd_digit #(.W(SEC_U_W), .MAX(9)) u_sec_units (
    .clk(clk), .reset(reset), .en(step), .clr(1'b0), .ld(load_ok),
    .ld_val(ld_sec[3:0]), .q(su_q), .d(su_d), .carry_out(su_co));
  bcd_digit #(.W(SEC_T_W), .MAX(5)) u_sec_tens (
    .clk(clk), .reset(reset), .en(su_co), .clr(1'b0), .ld(load_ok),
    .ld_val(ld_sec[6:4]), .q(st_q), .d(st_d), .carry_out(st_co));
  bcd_digit #(.W(MIN_U_W), .MAX(9)) u_min_units (
    .clk(clk), .reset(reset), .en(st_co), .clr(1'b0), .ld(load_ok),
    .ld_val(ld_min[3:0]), .q(mu_q), .d(mu_d), .carry_out(mu_co));
  bcd_digit #(.W(MIN_T_W), .MAX(5)) u_min_tens (
    .clk(clk), .reset(reset), .en(mu_co), .clr(1'b0), .ld(load_ok),
    .ld_val(ld_min[6:4]), .q(mt_q), .d(mt_d), .carry_out(mt_co));
  bcd_digit #(.W(HOUR_U_W), .MAX(9)) u_hour_units (
    .clk(clk), .reset(reset), .en(hour_en), .clr(day_wrap), .ld(load_ok),
    .ld_val(ld_hr[3:0]), .q(hu_q), .d(hu_d), .carry_out(hu_co));
  // The tens digit only ever reaches 2 at hour 2x, so its carry marks the day wrap.
  bcd_digit #(.W(HOUR_T_W), .MAX(2)) u_hour_tens (
    .clk(clk), .reset(reset), .en(hu_co || day_wrap), .clr(day_wrap), .ld(load_ok),
    .ld_val(ld_hr[5:4]), .q(ht_q), .d(ht_d), .carry_out(ht_co));

  assign hour_next = ({3'd0, ht_d} * 5'd10) + {1'b0, hu_d};

  // Prescaler and registered display/strobe next-state.
  always_comb begin
    cnt_d      = cnt_q;
    disp_d     = bin2bcd_5(mode_12h ? to_12h(hour_next) : hour_next);
    pm_d       = (hour_next >= 5'd12);
    tick_d     = step;
    rollover_d = ht_co;
    if (load_ok) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + DIV_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler, display and strobe registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      disp_q     <= 6'd0;
      pm_q       <= 1'b0;
      tick_q     <= 1'b0;
      rollover_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      disp_q     <= disp_d;
      pm_q       <= pm_d;
      tick_q     <= tick_d;
      rollover_q <= rollover_d;
      valid_q    <= 1'b1;
    end
  end

  assign sec_units = su_q;
  assign sec_tens  = st_q;
  assign min_units = mu_q;
  assign min_tens  = mt_q;
  assign pm        = pm_q;
  assign tick      = tick_q;
  assign rollover  = rollover_q;
  // Until the first edge after reset the display shows midnight in the selected mode.
  assign {hour_tens, hour_units} = valid_q ? disp_q : (mode_12h ? 6'h12 : 6'h00);

`ifdef TOD_ALARM_EN
  logic alarm_hit_q, alarm_hit_d;
  logic alarm_ok;

  assign alarm_ok = (alarm_hours <= 5'(HOUR_MAX)) && (alarm_minutes <= 6'(MIN_MAX));

  // Alarm fires only on a counted advance landing exactly on hh:mm:00.
  always_comb begin
    alarm_hit_d = 1'b0;
    if (step && alarm_arm && alarm_ok
        && ({ht_d, hu_d} == bin2bcd_5(alarm_hours))
        && ({mt_d, mu_d} == bin2bcd_6(alarm_minutes))
        && ({st_d, su_d} == 7'd0)) begin
      alarm_hit_d = 1'b1;
    end else begin
      alarm_hit_d = 1'b0;
    end
  end

  // Alarm strobe register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_hit_q <= 1'b0;
    end else begin
      alarm_hit_q <= alarm_hit_d;
    end
  end

  assign alarm_hit = alarm_hit_q;
`else
  logic unused_next;
  assign unused_next = ^{su_d, st_d, mu_d, mt_d};
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Self-checking bench for tod_counter with DIV=4. A seconds-of-day model
// predicts every output each cycle; directed literal checks pin the model.
module tb_tod_counter;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_hours = 5'd0;
  logic [5:0] load_minutes = 6'd0;
  logic [5:0] load_seconds = 6'd0;
  logic       mode_12h = 1'b0;
  logic [3:0] sec_units, min_units, hour_units;
  logic [2:0] sec_tens, min_tens;
  logic [1:0] hour_tens;
  logic       pm, tick, rollover;
`ifdef TOD_ALARM_EN
  logic       alarm_arm = 1'b0;
  logic [4:0] alarm_hours = 5'd0;
  logic [5:0] alarm_minutes = 6'd0;
  logic       alarm_hit;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tod_counter #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .mode_12h(mode_12h),
    .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units), .min_tens(min_tens),
    .hour_units(hour_units), .hour_tens(hour_tens),
    .pm(pm), .tick(tick), .rollover(rollover)
`ifdef TOD_ALARM_EN
    , .alarm_arm(alarm_arm), .alarm_hours(alarm_hours),
    .alarm_minutes(alarm_minutes), .alarm_hit(alarm_hit)
`endif
  );

  // ---------------- model: time as seconds since midnight ----------------
  int m_sec = 0;
  int m_cnt = 0;
  bit m_tick = 1'b0, m_roll = 1'b0, m_mode = 1'b0, m_valid = 1'b0, m_alarm = 1'b0;

  function automatic bit load_valid(input int h, input int m, input int s);
    return (h < 24) && (m < 60) && (s < 60);
  endfunction

  function automatic int hour12(input int h);
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sec <= 0; m_cnt <= 0; m_tick <= 1'b0; m_roll <= 1'b0;
      m_mode <= 1'b0; m_valid <= 1'b0; m_alarm <= 1'b0;
    end else begin
      m_mode  <= mode_12h;
      m_valid <= 1'b1;
      if (load && load_valid(int'(load_hours), int'(load_minutes), int'(load_seconds))) begin
        m_sec   <= int'(load_hours) * 3600 + int'(load_minutes) * 60 + int'(load_seconds);
        m_cnt   <= 0;
        m_tick  <= 1'b0;
        m_roll  <= 1'b0;
        m_alarm <= 1'b0;
      end else begin
        m_cnt <= enable ? (m_cnt + 1) % DIV : m_cnt;
        if (enable && m_cnt == DIV - 1) begin
          m_sec  <= (m_sec + 1) % 86400;
          m_tick <= 1'b1;
          m_roll <= (m_sec == 86399);
`ifdef TOD_ALARM_EN
          m_alarm <= alarm_arm && (alarm_hours < 24) && (alarm_minutes < 60)
                     && (((m_sec + 1) % 86400) == int'(alarm_hours) * 3600 + int'(alarm_minutes) * 60);
`else
          m_alarm <= 1'b0;
`endif
        end else begin
          m_tick  <= 1'b0;
          m_roll  <= 1'b0;
          m_alarm <= 1'b0;
        end
      end
    end
  end

  function automatic logic [22:0] exp_vec(input int sec, input bit mode_r, input bit valid,
                                           input bit mode_in, input bit tk, input bit rl);
    int h, m, s, dh;
    h  = sec / 3600;
    m  = (sec / 60) % 60;
    s  = sec % 60;
    dh = valid ? (mode_r ? hour12(h) : h) : (mode_in ? 12 : 0);
    return {3'(s / 10), 4'(s % 10), 3'(m / 10), 4'(m % 10),
            2'(dh / 10), 4'(dh % 10), (h >= 12), tk, rl};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("cycle_outputs",
        int'({sec_tens, sec_units, min_tens, min_units, hour_tens, hour_units, pm, tick, rollover}),
        int'(exp_vec(m_sec, m_mode, m_valid, mode_12h, m_tick, m_roll)));
`ifdef TOD_ALARM_EN
    chk("cycle_alarm_hit", int'(alarm_hit), int'(m_alarm));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1;
    load_hours = 5'(h);
    load_minutes = 6'(m);
    load_seconds = 6'(s);
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    // 1. reset mid-count, release, first tick after DIV enabled cycles
    enable = 1'b1;
    cyc(2);
    reset = 1'b1;
    cyc(6);
    chk("pre_reset_sec_units", int'(sec_units), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_sec_units", int'(sec_units), 0);
    chk("async_reset_hours_24h", int'({hour_tens, hour_units}), 'h00);
    chk("async_reset_tick", int'(tick), 0);
    mode_12h = 1'b1;
    #1;
    chk("reset_hours_12h", int'({hour_tens, hour_units}), 'h12);
    mode_12h = 1'b0;
    @(negedge clk);
    #1 reset = 1'b1;
    cyc(3);
    chk("no_tick_before_div", int'(tick), 0);
    chk("sec_units_before_div", int'(sec_units), 0);
    cyc(1);
    chk("first_tick", int'(tick), 1);
    chk("first_tick_sec_units", int'(sec_units), 1);
    cyc(1);
    chk("tick_one_cycle", int'(tick), 0);

    // 2. day rollover
    do_load(23, 59, 59);
    chk("load_235959_hours", int'({hour_tens, hour_units}), 'h23);
    chk("load_235959_pm", int'(pm), 1);
    cyc(3);
    chk("rollover_not_yet", int'(rollover), 0);
    cyc(1);
    chk("rollover_pulse", int'(rollover), 1);
    chk("rollover_tick", int'(tick), 1);
    chk("rollover_time", int'({hour_tens, hour_units, min_tens, min_units, sec_tens, sec_units}), 0);
    chk("rollover_pm", int'(pm), 0);
    cyc(1);
    chk("rollover_one_cycle", int'(rollover), 0);

    // 3. 12h display
    mode_12h = 1'b1;
    do_load(13, 5, 0);
    chk("h12_13_hours", int'({hour_tens, hour_units}), 'h01);
    chk("h12_13_pm", int'(pm), 1);
    chk("h12_13_min_units", int'(min_units), 5);
    do_load(0, 0, 0);
    chk("h12_00_hours", int'({hour_tens, hour_units}), 'h12);
    chk("h12_00_pm", int'(pm), 0);
    do_load(12, 0, 0);
    chk("h12_12_hours", int'({hour_tens, hour_units}), 'h12);
    chk("h12_12_pm", int'(pm), 1);
    do_load(12, 59, 57);
    cyc(12);
    chk("h12_1300_hours", int'({hour_tens, hour_units}), 'h01);
    mode_12h = 1'b0;
    cyc(1);
    chk("mode_back_24h", int'({hour_tens, hour_units}), 'h13);

    // 4. out-of-range loads ignored, prescaler keeps running
    do_load(8, 0, 0);
    do_load(24, 0, 0);
    do_load(10, 60, 0);
    chk("bad_load_hours", int'({hour_tens, hour_units}), 'h08);
    chk("bad_load_min", int'({min_tens, min_units}), 'h00);
    cyc(1);
    chk("bad_load_no_tick", int'(tick), 0);
    cyc(1);
    chk("bad_load_tick_on_time", int'(tick), 1);
    chk("bad_load_sec_units", int'(sec_units), 1);
    enable = 1'b0;
    do_load(10, 0, 0);
    chk("load_disabled_hours", int'({hour_tens, hour_units}), 'h10);
    cyc(10);
    chk("frozen_sec_units", int'(sec_units), 0);
    chk("frozen_hours", int'({hour_tens, hour_units}), 'h10);

    // 5. load on the advance cycle wins
    enable = 1'b1;
    cyc(3);
    do_load(5, 6, 7);
    chk("load_vs_adv_sec_units", int'(sec_units), 7);
    chk("load_vs_adv_tick", int'(tick), 0);
    cyc(3);
    chk("after_load_no_tick", int'(tick), 0);
    cyc(1);
    chk("after_load_tick_sec", int'(sec_units), 8);
    do_load(9, 59, 59);
    cyc(4);
    chk("hour_carry_0959", int'({hour_tens, hour_units}), 'h10);

`ifdef TOD_ALARM_EN
    // 6. alarm
    alarm_hours = 5'd7;
    alarm_minutes = 6'd30;
    alarm_arm = 1'b1;
    do_load(7, 29, 58);
    cyc(4);
    chk("alarm_not_at_2959", int'(alarm_hit), 0);
    cyc(4);
    chk("alarm_hit_0730", int'(alarm_hit), 1);
    chk("alarm_min_units", int'(min_units), 0);
    cyc(1);
    chk("alarm_one_cycle", int'(alarm_hit), 0);
    alarm_arm = 1'b0;
    do_load(7, 29, 59);
    cyc(4);
    chk("alarm_disarmed", int'(alarm_hit), 0);
`endif

    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
